// File: rtl/encoder_k3.sv
// Rate-1/2 feedforward convolutional encoder with run-time choice of
// K=3 (7,5 octal) or K=7 (171,133 octal); coded bits are registered.
module encoder_k3 #(
    parameter logic [2:0] G1_K3 = 3'b111,
    parameter logic [2:0] G2_K3 = 3'b101,
    parameter logic [6:0] G1_K7 = 7'b1111001,
    parameter logic [6:0] G2_K7 = 7'b1011011
) (
    input  logic clk,
    input  logic rst,
    input  logic unencoded_bits,
    input  logic choose_constraint_length,
    output logic output1,
    output logic output2
);

    // Even-parity of the taps selected by a generator mask.
    function automatic logic tap_parity(input logic [6:0] taps, input logic [6:0] gen);
        tap_parity = ^(taps & gen);
    endfunction

    logic [5:0] r_shift;
    logic       r_out1;
    logic       r_out2;
    logic [6:0] w_taps;
    logic [6:0] w_gen1;
    logic [6:0] w_gen2;
    logic       w_code1;
    logic       w_code2;

    // Tap vector {u, s0..s5} and generator masks aligned to the current input at the MSB.
    always_comb begin
        w_taps = {unencoded_bits, r_shift[0], r_shift[1], r_shift[2],
                  r_shift[3], r_shift[4], r_shift[5]};
        w_gen1 = 7'b0000000;
        w_gen2 = 7'b0000000;
        if (choose_constraint_length) begin
            w_gen1 = G1_K7;
            w_gen2 = G2_K7;
        end else begin
            w_gen1 = {G1_K3, 4'b0000};
            w_gen2 = {G2_K3, 4'b0000};
        end
        w_code1 = tap_parity(w_taps, w_gen1);
        w_code2 = tap_parity(w_taps, w_gen2);
    end

    // History shift and output registers; all six stages shift in both modes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= 6'b000000;
            r_out1  <= 1'b0;
            r_out2  <= 1'b0;
        end else begin
            r_shift <= {r_shift[4:0], unencoded_bits};
            r_out1  <= w_code1;
            r_out2  <= w_code2;
        end
    end

    assign output1 = r_out1;
    assign output2 = r_out2;

endmodule

// File: tb/tb_encoder_k3.sv
// Self-checking bench for encoder_k3: directed vectors plus randomized
// traffic against a polynomial-convolution reference model.
module tb_encoder_k3;

    logic clk;
    logic rst;
    logic unencoded_bits;
    logic choose_constraint_length;
    logic output1;
    logic output2;

    int checks;
    int failures;
    bit hist [6];

    encoder_k3 dut (
        .clk                      (clk),
        .rst                      (rst),
        .unencoded_bits           (unencoded_bits),
        .choose_constraint_length (choose_constraint_length),
        .output1                  (output1),
        .output2                  (output2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 6; i++) hist[i] = 1'b0;
    endtask

    // Reference: c[n] = XOR_j g_j * x[n-j], with the generator written in octal and its MSB on x[n].
    function automatic logic [1:0] model(input bit u, input bit k7);
        int g1, g2, k;
        bit x, a1, a2;
        g1 = k7 ? 'o171 : 'o7;
        g2 = k7 ? 'o133 : 'o5;
        k  = k7 ? 7 : 3;
        a1 = 1'b0;
        a2 = 1'b0;
        for (int j = 0; j < k; j++) begin
            x = (j == 0) ? u : hist[j-1];
            if (((g1 >> (k - 1 - j)) & 1) == 1) a1 ^= x;
            if (((g2 >> (k - 1 - j)) & 1) == 1) a2 ^= x;
        end
        return {a1, a2};
    endfunction

    // One clock: drive, wait for the edge, sample 1 time unit later, compare.
    task automatic step(input bit u, input bit k7, input string tag);
        logic [1:0] exp;
        unencoded_bits = u;
        choose_constraint_length = k7;
        exp = model(u, k7);
        for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = u;
        @(posedge clk);
        #1;
        check(tag, {output1, output2}, exp);
    endtask

    task automatic step_exp(input bit u, input bit k7, input logic [1:0] exp, input string tag);
        step(u, k7, tag);
        check({tag, "_tbl"}, {output1, output2}, exp);
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        check("reset_async", {output1, output2}, 2'b00);
        @(posedge clk);
        #1;
        check("reset_hold", {output1, output2}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        clear_model();
    endtask

    initial begin
        logic [1:0] k3_tbl [10];
        bit         k3_in  [10];
        logic [6:0] k7_o1;
        logic [6:0] k7_o2;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        unencoded_bits = 1'b0;
        choose_constraint_length = 1'b0;
        clear_model();
        #2;
        rst = 1'b0;
        #1;
        check("reset_initial", {output1, output2}, 2'b00);
        @(negedge clk);
        rst = 1'b1;

        // All-ones steady state in both modes, then mid-stream reset.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "k3_ones");
        check("k3_ones_steady", {output1, output2}, 2'b10);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, "k7_ones");
        check("k7_ones_steady", {output1, output2}, 2'b11);
        unencoded_bits = 1'b1;
        do_reset();
        step_exp(1'b0, 1'b0, 2'b00, "post_reset_zero");

        // K=3 directed sequence from reset.
        do_reset();
        k3_in  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        k3_tbl = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 10; i++) step_exp(k3_in[i], 1'b0, k3_tbl[i], "k3_seq");

        // K=3 impulse.
        do_reset();
        step_exp(1'b1, 1'b0, 2'b11, "k3_imp0");
        step_exp(1'b0, 1'b0, 2'b10, "k3_imp1");
        step_exp(1'b0, 1'b0, 2'b11, "k3_imp2");
        step_exp(1'b0, 1'b0, 2'b00, "k3_imp3");

        // K=7 impulse.
        do_reset();
        k7_o1 = 7'b1111001;
        k7_o2 = 7'b1011011;
        step_exp(1'b1, 1'b1, {k7_o1[6], k7_o2[6]}, "k7_imp");
        for (int i = 5; i >= 0; i--) step_exp(1'b0, 1'b1, {k7_o1[i], k7_o2[i]}, "k7_imp");
        step_exp(1'b0, 1'b1, 2'b00, "k7_imp_tail");

        // Mode switch keeps history.
        do_reset();
        step(1'b1, 1'b0, "sw_load");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "sw_load");
        step_exp(1'b0, 1'b1, 2'b00, "sw_s3");
        step_exp(1'b0, 1'b1, 2'b01, "sw_s4");

        // Randomized traffic with occasional mode flips and resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) > 3), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
